// File: rtl/noc_pkg.sv
// Shared NoC definitions: default flit width, flit type, router port count
// and a ceiling-log2 helper used to size round-robin pointers.
package noc_pkg;

  localparam int DATA_WIDTH = 64;
  localparam int NUM_PORTS  = 4;

  typedef logic [DATA_WIDTH-1:0] flit_t;

  // Pointer width for an n-entry round robin; never returns less than 1.
  function automatic int clog2(input int n);
    int w;
    w = 1;
    while ((1 << w) < n) w++;
    return w;
  endfunction

endpackage

// File: rtl/rr_output_arbiter_if.sv
// Output-port bundle between the per-input channel buffers, the arbiter and
// the downstream channel buffer.
//   in_empty/in_route/in_data : upstream buffer heads (bit/slice i = input i)
//   in_re                     : one-hot pop strobe back to the upstream buffers
//   out_full/out_we/out_data  : write side of the downstream buffer
//   flit_count                : flits delivered downstream
// slave is the arbiter's view, master the surrounding router's view.
interface rr_output_arbiter_if
  import noc_pkg::*;
#(
  parameter int DATA_WIDTH = noc_pkg::DATA_WIDTH,
  parameter int NUM_IN     = noc_pkg::NUM_PORTS,
  parameter int CNT_WIDTH  = 16
);
  logic [NUM_IN-1:0]            in_empty;
  logic [NUM_IN-1:0]            in_route;
  logic [NUM_IN*DATA_WIDTH-1:0] in_data;
  logic [NUM_IN-1:0]            in_re;
  logic                         out_full;
  logic                         out_we;
  logic [DATA_WIDTH-1:0]        out_data;
  logic [CNT_WIDTH-1:0]         flit_count;

  modport master (
    output in_empty, in_route, in_data, out_full,
    input  in_re, out_we, out_data, flit_count
  );

  modport slave (
    input  in_empty, in_route, in_data, out_full,
    output in_re, out_we, out_data, flit_count
  );
endinterface

// File: rtl/rr_output_arbiter_rr_pick.sv
// Combinational round-robin selector.
//   req   : request vector
//   ptr   : highest-priority index this cycle
//   grant : one-hot winner (zero when nobody requests)
//   idx   : binary index of the winner
//   any   : at least one request present
module rr_pick
  import noc_pkg::*;
#(
  parameter int NUM_IN = noc_pkg::NUM_PORTS,
  parameter int PTR_W  = clog2(NUM_IN)
) (
  input  logic [NUM_IN-1:0] req,
  input  logic [PTR_W-1:0]  ptr,
  output logic [NUM_IN-1:0] grant,
  output logic [PTR_W-1:0]  idx,
  output logic              any
);

  int i;

  // Scan from the lowest priority back to ptr so the last hit is the winner.
  always_comb begin
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    i     = 0;
    for (int k = NUM_IN - 1; k >= 0; k--) begin
      i = (int'(ptr) + k) % NUM_IN;
      if (req[i]) begin
        grant    = '0;
        grant[i] = 1'b1;
        idx      = PTR_W'(i);
        any      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rr_output_arbiter.sv
// Router output-port stage. Each cycle it pops one non-empty, route-matching
// upstream buffer (round robin) into a one-entry hold register that feeds the
// downstream buffer. A drain and a refill can share a cycle, so throughput is
// one flit per clock.
//   clk, reset : clock and synchronous active-high reset
//   bus        : rr_output_arbiter_if.slave (see interface for signal list)
module rr_output_arbiter
  import noc_pkg::*;
#(
  parameter int DATA_WIDTH = noc_pkg::DATA_WIDTH,
  parameter int NUM_IN     = noc_pkg::NUM_PORTS,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  rr_output_arbiter_if.slave   bus
);

  localparam int PTR_W = clog2(NUM_IN);

  logic                  hold_valid;
  logic [DATA_WIDTH-1:0] hold_data;
  logic [PTR_W-1:0]      ptr;
  logic [CNT_WIDTH-1:0]  cnt;

  logic [NUM_IN-1:0]     req;
  logic [NUM_IN-1:0]     pick_oh;
  logic [PTR_W-1:0]      pick_idx;
  logic                  pick_any;
  logic                  free;
  logic                  do_grant;
  logic                  xfer;

  assign req = ~bus.in_empty & bus.in_route;

  rr_pick #(
    .NUM_IN (NUM_IN),
    .PTR_W  (PTR_W)
  ) u_pick (
    .req   (req),
    .ptr   (ptr),
    .grant (pick_oh),
    .idx   (pick_idx),
    .any   (pick_any)
  );

  // The slot can accept a new flit if empty or if its occupant leaves this edge.
  assign free     = ~hold_valid | ~bus.out_full;
  assign do_grant = free & pick_any & ~reset;
  assign xfer     = hold_valid & ~bus.out_full & ~reset;

  // Outputs are forced quiet while reset is high so a held flit is not
  // written downstream in the reset cycle.
  assign bus.in_re      = do_grant ? pick_oh : '0;
  assign bus.out_we     = hold_valid & ~reset;
  assign bus.out_data   = reset ? '0 : hold_data;
  assign bus.flit_count = reset ? '0 : cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      hold_valid <= 1'b0;
      hold_data  <= '0;
      ptr        <= '0;
      cnt        <= '0;
    end else begin
      if (xfer) cnt <= cnt + 1'b1;
      if (do_grant) begin
        hold_valid <= 1'b1;
        hold_data  <= bus.in_data[pick_idx*DATA_WIDTH +: DATA_WIDTH];
        if (int'(pick_idx) == NUM_IN - 1) ptr <= '0;
        else                              ptr <= pick_idx + 1'b1;
      end else if (xfer) begin
        hold_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_rr_output_arbiter.sv
module tb_rr_output_arbiter;
  import noc_pkg::*;

  localparam int DW = 64;
  localparam int NI = 4;
  localparam int CW = 4;

  logic clk = 1'b0;
  logic reset;

  rr_output_arbiter_if #(.DATA_WIDTH(DW), .NUM_IN(NI), .CNT_WIDTH(CW)) ifc ();

  rr_output_arbiter #(.DATA_WIDTH(DW), .NUM_IN(NI), .CNT_WIDTH(CW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (ifc.slave)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Reference model state
  bit    m_valid;
  flit_t m_data;
  int    m_ptr;
  int    m_count;
  flit_t heads [NI];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h expected=%h at %0t", tag, got, exp, $time);
    end
  endtask

  // One clock cycle: apply inputs, compare at the falling edge, advance model.
  task automatic cycle(input bit r, input logic [NI-1:0] empty,
                       input logic [NI-1:0] route, input bit full);
    int g;
    logic [NI-1:0] exp_re;
    bit xfer;
    reset        = r;
    ifc.in_empty = empty;
    ifc.in_route = route;
    ifc.out_full = full;
    for (int i = 0; i < NI; i++) begin
      heads[i] = {$urandom(), $urandom()};
      ifc.in_data[i*DW +: DW] = heads[i];
    end
    @(negedge clk);
    g = -1;
    if (!r && (!m_valid || !full)) begin
      for (int k = 0; k < NI; k++) begin
        int c;
        c = (m_ptr + k) % NI;
        if (g < 0 && !empty[c] && route[c]) g = c;
      end
    end
    exp_re = (g >= 0) ? NI'(1 << g) : '0;
    check("in_re", 64'(ifc.in_re), 64'(exp_re));
    check("out_we", 64'(ifc.out_we), 64'(!r && m_valid));
    check("out_data", ifc.out_data, r ? 64'd0 : m_data);
    check("flit_count", 64'(ifc.flit_count), r ? 64'd0 : 64'(m_count));
    @(posedge clk);
    if (r) begin
      m_valid = 0; m_data = '0; m_ptr = 0; m_count = 0;
    end else begin
      xfer = m_valid && !full;
      if (xfer) m_count = (m_count + 1) % (1 << CW);
      if (g >= 0) begin
        m_valid = 1; m_data = heads[g]; m_ptr = (g + 1) % NI;
      end else if (xfer) begin
        m_valid = 0;
      end
    end
    #1;
  endtask

  initial begin
    reset = 1'b1;
    ifc.in_empty = '1;
    ifc.in_route = '0;
    ifc.in_data  = '0;
    ifc.out_full = 1'b0;
    m_valid = 0; m_data = '0; m_ptr = 0; m_count = 0;
    @(posedge clk); #1;

    // Reset held with all inputs requesting
    cycle(1, 4'b0000, 4'b1111, 0);
    cycle(1, 4'b0000, 4'b1111, 0);
    // First grant after release goes to input 0, then drain
    cycle(0, 4'b0000, 4'b1111, 0);
    cycle(0, 4'b1111, 4'b1111, 0);

    // Single input 2 with a fixed flit
    reset = 0;
    ifc.in_empty = 4'b1011; ifc.in_route = 4'b0100; ifc.out_full = 0;
    ifc.in_data[2*DW +: DW] = 64'hA5A5_0000_0000_0002;
    @(negedge clk);
    check("single_re", 64'(ifc.in_re), 64'h4);
    @(posedge clk); #1;
    m_valid = 1; m_data = 64'hA5A5_0000_0000_0002; m_ptr = 3;
    ifc.in_empty = 4'b1111;
    @(negedge clk);
    check("single_we", 64'(ifc.out_we), 64'h1);
    check("single_data", ifc.out_data, 64'hA5A5_0000_0000_0002);
    @(posedge clk); #1;
    m_valid = 0; m_count = (m_count + 1) % (1 << CW);
    cycle(0, 4'b1111, 4'b1111, 0);

    // All four continuously requesting from a fresh pointer
    cycle(1, 4'b1111, 4'b0000, 0);
    for (int n = 0; n < 9; n++) cycle(0, 4'b0000, 4'b1111, 0);

    // Backpressure: held flit stalls for 5 cycles, then drain + refill together
    for (int n = 0; n < 5; n++) cycle(0, 4'b0000, 4'b1111, 1);
    cycle(0, 4'b0000, 4'b1111, 0);
    cycle(0, 4'b1111, 4'b1111, 0);

    // Route mask: only input 3 may pop until input 1's route appears
    for (int n = 0; n < 3; n++) cycle(0, 4'b0101, 4'b1000, 0);
    for (int n = 0; n < 3; n++) cycle(0, 4'b0101, 4'b1010, 0);

    // Counter wrap: 17+ transfers through a 4-bit counter
    cycle(1, 4'b1111, 4'b0000, 0);
    for (int n = 0; n < 18; n++) cycle(0, 4'b0000, 4'b1111, 0);

    // Reset mid-burst with a held flit, then idle
    cycle(1, 4'b0000, 4'b1111, 0);
    cycle(0, 4'b1111, 4'b1111, 0);
    cycle(0, 4'b1111, 4'b1111, 0);

    // Randomized traffic
    for (int n = 0; n < 400; n++)
      cycle(($urandom_range(0, 49) == 0), NI'($urandom()), NI'($urandom()),
            ($urandom_range(0, 3) == 0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
